// File: rtl/muldiv_hilo_pkg.sv
// Shared op codes, FSM state encoding and a small sign helper for the
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } state_t;

    // Two's-complement negate when neg is set; 0x80000000 maps onto itself.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_hilo_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_hilo_divu_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step.
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // One extra bit so a divisor above 2^(WIDTH-1) cannot overflow the shift.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_div};
    assign w_fits    = (w_shifted >= {1'b0, r_div});

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
        end
    end

    assign o_quo = r_quo;
    assign o_rem = r_rem;

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS multiply/divide unit owning HI/LO: single-cycle multiply, iterative
// restoring divide with sign fix-up and a flushable busy window.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIV_ITER = WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_hilo_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV_ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a_raw;

    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_load;
    logic               w_step;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign w_signed = (bus.op == OP_DIV);
    assign w_sa     = w_signed & bus.a[WIDTH-1];
    assign w_sb     = w_signed & bus.b[WIDTH-1];
    assign w_a_abs  = w_sa ? (WIDTH'(0) - bus.a) : bus.a;
    assign w_b_abs  = w_sb ? (WIDTH'(0) - bus.b) : bus.b;

    assign w_load = (r_state == S_IDLE) && bus.start && !bus.flush && w_is_div;
    assign w_step = (r_state == S_DIV_RUN) && !bus.flush;

    assign w_prod_s = $signed(bus.a) * $signed(bus.b);
    assign w_prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

    divu_iter #(.WIDTH(WIDTH)) u_divu_iter (
        .clk        (clk),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_a_abs),
        .i_divisor  (w_b_abs),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_a_raw <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OP_MULT: begin
                                {r_hi, r_lo} <= w_prod_s;
                                r_done       <= 1'b1;
                            end
                            OP_MULTU: begin
                                {r_hi, r_lo} <= w_prod_u;
                                r_done       <= 1'b1;
                            end
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            OP_DIV, OP_DIVU: begin
                                r_state <= S_DIV_RUN;
                                r_cnt   <= '0;
                                r_neg_q <= w_sa ^ w_sb;
                                r_neg_r <= w_sa;
                                r_dz    <= (bus.b == '0);
                                r_a_raw <= bus.a;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT)
                            r_state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    r_state <= S_IDLE;
                    // Divide by zero reports all-ones quotient and the untouched dividend.
                    if (!bus.flush) begin
                        r_lo   <= r_dz ? '1 : cond_neg(w_quo, r_neg_q);
                        r_hi   <= r_dz ? r_a_raw : cond_neg(w_rem, r_neg_r);
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: directed MULT/DIV/MTxx/flush/reset cases.
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;

    muldiv_hilo_if #(.WIDTH(32)) bus ();

    muldiv_hilo #(.WIDTH(32), .DIV_ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Called on a falling edge; start is seen by exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic fl);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.flush = fl;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout actual=%0d expected<100", cycles);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=1 expected=0 hi=0x%08h lo=0x%08h",
                             bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hi", bus.hi, e[63:32]);
                    chk("sb_lo", bus.lo, e[31:0]);
                end
            end
        end
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -1 * 2
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_busy", {31'd0, bus.busy}, 32'd0);
        chk("mult_done", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk("mult_done_width", {31'd0, bus.done}, 32'd0);

        // MULTU same operands
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        @(negedge clk);

        // DIV -7 / 2: latency and sign handling
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        count_busy(cyc);
        chk("div_busy_cycles", cyc, 32'd33);
        chk("div_done_cycle34", {31'd0, bus.done}, 32'd1);
        @(negedge clk);

        // DIV 7 / -2 -> q=-3, r=1
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        count_busy(cyc);
        @(negedge clk);

        // DIVU 100 / 0
        exp_q.push_back({32'd100, 32'hFFFF_FFFF});
        issue(OP_DIVU, 32'd100, 32'd0, 1'b0);
        count_busy(cyc);
        chk("divz_busy_cycles", cyc, 32'd33);
        @(negedge clk);

        // Signed overflow
        exp_q.push_back({32'h0, 32'h8000_0000});
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        count_busy(cyc);
        @(negedge clk);

        // DIVU 100 / 7 with an ignored MULT issued while busy
        exp_q.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        issue(OP_MULT, 32'd3, 32'd3, 1'b0);
        count_busy(cyc);
        @(negedge clk);

        // Start together with flush is dropped
        issue(OP_MULT, 32'd5, 32'd5, 1'b1);
        chk("flushstart_hi", bus.hi, 32'd2);
        chk("flushstart_lo", bus.lo, 32'd14);

        // MTHI/MTLO then flushed DIVU
        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h5678, 32'd0, 1'b0);
        chk("mthi", bus.hi, 32'h1234);
        chk("mtlo", bus.lo, 32'h5678);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        chk("flush_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_hi", bus.hi, 32'h1234);
        chk("flush_lo", bus.lo, 32'h5678);
        repeat (40) @(negedge clk);
        chk("flush_hi_later", bus.hi, 32'h1234);
        chk("flush_lo_later", bus.lo, 32'h5678);

        // Reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multiply/divide execution unit for the MIPS core.
- Owns the HI/LO architectural registers.
- Sits beside the EX stage. Its hi/lo outputs feed the EX result-select multiplexer (MFHI/MFLO path).
- Multiply completes in one cycle. Divide is a 32-iteration restoring divider; busy stalls the pipeline while it runs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV_ITER, WIDTH, number of divider iteration cycles.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue pulse for op; sampled only in IDLE
- op  in  3  operation code (package constants)
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- flush  in  1  abort in-flight divide; drop a same-cycle start
- busy  out  1  unit occupied; pipeline holds EX while high
- done  out  1  one-cycle pulse after a MULT/DIV result is written to HI/LO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0; lo=0; busy=0; done=0; iteration counter=0.
  - Reset mid-divide discards the operation.
- States:
  - IDLE: accepts start.
  - DIV_RUN: DIV_ITER cycles.
  - DIV_FIX: 1 cycle; sign correction and HI/LO write.
- busy = (state != IDLE). It is registered state, not combinational from start.
- start in IDLE with flush=0:
  - OP_MULT/OP_MULTU: {hi,lo} <= signed/unsigned 2*WIDTH product at the next edge; done=1 the following cycle; state stays IDLE; busy stays 0.
  - OP_MTHI: hi <= a at the next edge. OP_MTLO: lo <= a at the next edge. No done pulse.
  - OP_DIV/OP_DIVU: latch |a| and |b| (raw values for DIVU) plus the two operand signs. Go to DIV_RUN with counter=0.
  - Other op codes: ignored, no state change.
- DIV_RUN, each cycle:
  - Shift {rem,quo} left by one bit.
  - Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set the quotient LSB.
  - The counter increments. When the counter reaches DIV_ITER-1, go to DIV_FIX.
- DIV_FIX, signed case:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - lo <= quotient; hi <= remainder; state -> IDLE; done=1 the next cycle.
- Divide latency:
  - Accept at edge 0.
  - HI/LO written at edge DIV_ITER+1 (edge 33).
  - done high in cycle 34.
  - busy high during cycles 1..33.
- Divide by zero is a defined, non-trapping result: lo=all ones, hi=dividend a (signed or unsigned). It still takes full latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored. The pipeline must not issue; no error flag.
- flush:
  - In DIV_RUN or DIV_FIX: state -> IDLE at the next edge, HI/LO unchanged, no done.
  - flush with start in IDLE: start dropped, including MULT and MTHI/MTLO.
- done is exactly one cycle wide, deasserted otherwise. A new start may be accepted in the same cycle done is high.

Decomposition:
- Package muldiv_pkg holds:
  - op localparams OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5;
  - state encoding S_IDLE, S_DIV_RUN, S_DIV_FIX.
- One sub-module, divu_iter: an unsigned restoring iteration datapath (remainder/quotient shift register plus trial subtractor). It has load/step controls and exposes quo/rem.
- The top level holds the FSM, sign handling, the multiplier and HI/LO.

Test Plan:
- Reset then MULT a=0xFFFFFFFF (-1), b=2 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle, busy never high.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2:
  - busy high exactly 33 cycles;
  - then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
  - done in cycle 34.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 after full latency.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7 after MTHI a=0x1234 and MTLO a=0x5678; flush at cycle 10 -> busy drops next cycle, hi=0x1234, lo=0x5678, no done.
- Then start DIVU 100/7 with rst_n pulsed low mid-run -> hi=lo=0, busy=0 immediately.
